gpu_clut_loader: RTL

- Downstream consumer of the CLUT manager's load request. Fetches 32-byte CLUT blocks from VRAM through the GPU memory read port and writes them into the CLUT cache RAM.
- Drives the manager's packet-decrement and end-of-load strobes.
- 4bpp palettes take 1 block; 8bpp palettes take 16 blocks, fetched from highest block index down to 0.

---
 rtl/gpu_clut_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/gpu_clut_loader.sv
// ============================================================================
// Module   : gpu_clut_loader
// Brief    : Fetches 32-byte CLUT blocks from VRAM and writes them into the
//            CLUT cache; drives the manager's decrement and end-of-load pulses.
//            Optional statistics outputs under GPU_CLUT_LOADER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_clut_loader #(
  parameter int DATA_W     = 32,
  parameter int BEAT_CNT_W = 3
) (
  input  logic                    i_clk,
  input  logic                    i_nRstGPU,
  input  logic                    i_isLoadingPalette,
  input  logic                    i_stillRemainingClutPacket,
  input  logic [14:0]             i_adrClutCacheUpdate,
  input  logic [3:0]              i_currentClutBlock,
  output logic                    o_decClutCount,
  output logic                    o_endClutLoading,
  output logic                    o_memReq,
  output logic [14:0]             o_memAdr,
  input  logic                    i_memAck,
  input  logic                    i_memDataValid,
  input  logic [DATA_W-1:0]       i_memData,
  output logic                    o_clutWrite,
  output logic [4+BEAT_CNT_W-1:0] o_clutWrAdr,
  output logic [DATA_W-1:0]       o_clutWrData,
  output logic                    o_busy
`ifdef GPU_CLUT_LOADER_STATS_EN
  ,
  output logic [15:0]             o_statBlocks,
  output logic                    o_statProtoErr
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DEC   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [BEAT_CNT_W-1:0] C_LAST_BEAT = '1;

  state_t                    state_q, state_d;
  logic [14:0]               adr_q, adr_d;
  logic [3:0]                blk_q, blk_d;
  logic [BEAT_CNT_W-1:0]     beat_q, beat_d;
  logic                      mem_req_q, mem_req_d;
  logic                      wr_q, wr_d;
  logic [4+BEAT_CNT_W-1:0]   wr_adr_q, wr_adr_d;
  logic [DATA_W-1:0]         wr_data_q, wr_data_d;
  logic                      dec_q, dec_d;
  logic                      end_q, end_d;
  logic                      busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    blk_d     = blk_q;
    beat_d    = beat_q;
    wr_d      = 1'b0;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (i_isLoadingPalette) begin
          if (i_stillRemainingClutPacket) begin
            state_d = ST_REQ;
            adr_d   = i_adrClutCacheUpdate;
            blk_d   = i_currentClutBlock - 4'd1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (i_memAck) begin
          state_d = ST_DATA;
          beat_d  = '0;
        end
      end
      ST_DATA: begin
        if (i_memDataValid) begin
          wr_d      = 1'b1;
          wr_adr_d  = {blk_q, beat_q};
          wr_data_d = i_memData;
          beat_d    = beat_q + BEAT_CNT_W'(1);
          if (beat_q == C_LAST_BEAT) begin
            state_d = ST_DEC;
          end
        end
      end
      ST_DEC: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // Count was decremented by the manager on the DEC edge
        if (i_stillRemainingClutPacket) begin
          state_d = ST_REQ;
          adr_d   = i_adrClutCacheUpdate;
          blk_d   = i_currentClutBlock - 4'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it
    mem_req_d = (state_d == ST_REQ);
    dec_d     = (state_d == ST_DEC);
    end_d     = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_nRstGPU) begin
    if (!i_nRstGPU) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      blk_q     <= '0;
      beat_q    <= '0;
      mem_req_q <= 1'b0;
      wr_q      <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      dec_q     <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      blk_q     <= blk_d;
      beat_q    <= beat_d;
      mem_req_q <= mem_req_d;
      wr_q      <= wr_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      dec_q     <= dec_d;
      end_q     <= end_d;
      busy_q    <= busy_d;
    end
  end

  assign o_memReq         = mem_req_q;
  assign o_memAdr         = adr_q;
  assign o_clutWrite      = wr_q;
  assign o_clutWrAdr      = wr_adr_q;
  assign o_clutWrData     = wr_data_q;
  assign o_decClutCount   = dec_q;
  assign o_endClutLoading = end_q;
  assign o_busy           = busy_q;

`ifdef GPU_CLUT_LOADER_STATS_EN
  logic [15:0] stat_blocks_q, stat_blocks_d;
  logic        proto_err_q, proto_err_d;

  always_comb begin
    stat_blocks_d = stat_blocks_q + ((state_q == ST_DEC) ? 16'd1 : 16'd0);
    proto_err_d   = proto_err_q
                  | (i_memDataValid && (state_q != ST_DATA))
                  | (i_memAck && (state_q != ST_REQ));
  end

  always_ff @(posedge i_clk or negedge i_nRstGPU) begin
    if (!i_nRstGPU) begin
      stat_blocks_q <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      stat_blocks_q <= stat_blocks_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign o_statBlocks   = stat_blocks_q;
  assign o_statProtoErr = proto_err_q;
`endif

endmodule

`default_nettype wire
